// File: rtl/bram_sequencer.sv
// Sequences a single-port BRAM through one pass of N writes, then N reads.
// Each pass ends with a drain cycle and a one-cycle done pulse.
module bram_sequencer #(
    parameter int BRAM_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  in_valid,
    input  logic                  compute_stall,
    output logic                  in_ready,
    output logic                  bram_en,
    output logic                  write_mode,
    output logic [BRAM_DEPTH-1:0] address,
    output logic                  rd_valid,
    output logic                  rd_last,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [BRAM_DEPTH-1:0] ADDR_MAX  = {BRAM_DEPTH{1'b1}};
    localparam logic [BRAM_DEPTH-1:0] ADDR_ZERO = {BRAM_DEPTH{1'b0}};
    localparam logic [BRAM_DEPTH-1:0] ADDR_ONE  = BRAM_DEPTH'(1'b1);

    state_t                state_r;
    state_t                next_state_s;
    logic [BRAM_DEPTH-1:0] addr_r;
    logic [BRAM_DEPTH-1:0] next_addr_s;
    logic                  rd_valid_r;
    logic                  rd_last_r;
    logic                  next_rd_valid_s;
    logic                  next_rd_last_s;

    // State, address and read-valid pipeline registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= S_IDLE;
            addr_r     <= ADDR_ZERO;
            rd_valid_r <= 1'b0;
            rd_last_r  <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            addr_r     <= next_addr_s;
            rd_valid_r <= next_rd_valid_s;
            rd_last_r  <= next_rd_last_s;
        end
    end

    // Next-state, address and BRAM port control decode.
    always_comb begin
        next_state_s    = state_r;
        next_addr_s     = addr_r;
        next_rd_valid_s = 1'b0;
        next_rd_last_s  = 1'b0;
        in_ready        = 1'b0;
        bram_en         = 1'b0;
        write_mode      = 1'b0;
        done            = 1'b0;
        busy            = (state_r != S_IDLE);

        case (state_r)
            S_IDLE: begin
                if (start) begin
                    next_state_s = S_LOAD;
                    next_addr_s  = ADDR_ZERO;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_LOAD: begin
                // A write coinciding with abort still lands; only the address is reset.
                in_ready   = 1'b1;
                bram_en    = in_valid;
                write_mode = in_valid;
                if (abort) begin
                    next_state_s = S_IDLE;
                    next_addr_s  = ADDR_ZERO;
                end else if (in_valid) begin
                    next_addr_s  = addr_r + ADDR_ONE;
                    next_state_s = (addr_r == ADDR_MAX) ? S_READ : S_LOAD;
                end else begin
                    next_state_s = S_LOAD;
                end
            end
            S_READ: begin
                if (abort) begin
                    next_state_s = S_IDLE;
                    next_addr_s  = ADDR_ZERO;
                end else if (!compute_stall) begin
                    bram_en         = 1'b1;
                    next_addr_s     = addr_r + ADDR_ONE;
                    next_rd_valid_s = 1'b1;
                    next_rd_last_s  = (addr_r == ADDR_MAX);
                    next_state_s    = (addr_r == ADDR_MAX) ? S_DRAIN : S_READ;
                end else begin
                    next_state_s = S_READ;
                end
            end
            S_DRAIN: begin
                next_addr_s  = ADDR_ZERO;
                next_state_s = abort ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                done         = 1'b1;
                next_state_s = S_IDLE;
            end
            default: begin
                next_state_s = S_IDLE;
                next_addr_s  = ADDR_ZERO;
            end
        endcase
    end

    assign address  = addr_r;
    assign rd_valid = rd_valid_r;
    assign rd_last  = rd_last_r;

endmodule

// File: tb/tb_bram_sequencer.sv
// Self-checking bench: directed scenarios plus random traffic, all compared
// each cycle against a count-based reference model of one load/read pass.
module tb_bram_sequencer;

    localparam int D = 2;
    localparam int N = 1 << D;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         abort;
    logic         in_valid;
    logic         compute_stall;
    logic         in_ready;
    logic         bram_en;
    logic         write_mode;
    logic [D-1:0] address;
    logic         rd_valid;
    logic         rd_last;
    logic         busy;
    logic         done;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: a pass is described by how many words were written and read.
    bit m_busy;
    int m_wr;
    int m_rd;
    int m_post;
    bit m_lastrd;
    int m_lastaddr;

    always #5 clk = ~clk;

    bram_sequencer #(.BRAM_DEPTH(D)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .in_valid(in_valid), .compute_stall(compute_stall),
        .in_ready(in_ready), .bram_en(bram_en), .write_mode(write_mode),
        .address(address), .rd_valid(rd_valid), .rd_last(rd_last),
        .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_wr = 0; m_rd = 0; m_post = 0;
        m_lastrd = 1'b0; m_lastaddr = 0;
    endtask

    task automatic cycle(input logic s, input logic a, input logic iv, input logic cs);
        bit ld, rdp, dr, issue;
        int exp_addr, rd_before;
        @(negedge clk);
        start = s; abort = a; in_valid = iv; compute_stall = cs;
        #1;
        ld    = m_busy && (m_wr < N);
        rdp   = m_busy && (m_wr == N) && (m_rd < N);
        dr    = m_busy && (m_rd == N) && (m_post == 0);
        issue = rdp && !cs && !a;
        exp_addr = ld ? m_wr : (rdp ? m_rd : 0);
        check("in_ready",   32'(in_ready),   32'(ld));
        check("bram_en",    32'(bram_en),    32'((ld && iv) || issue));
        check("write_mode", 32'(write_mode), 32'(ld && iv));
        check("address",    32'(address),    32'(exp_addr));
        check("rd_valid",   32'(rd_valid),   32'(m_lastrd));
        check("rd_last",    32'(rd_last),    32'(m_lastrd && (m_lastaddr == N - 1)));
        check("busy",       32'(busy),       32'(m_busy));
        check("done",       32'(done),       32'(m_busy && (m_rd == N) && (m_post == 1)));
        rd_before = m_rd;
        if (!m_busy) begin
            if (s) begin
                m_busy = 1'b1; m_wr = 0; m_rd = 0; m_post = 0;
            end
        end else if (a && (ld || rdp || dr)) begin
            m_busy = 1'b0;
        end else if (ld) begin
            if (iv) m_wr++;
        end else if (rdp) begin
            if (issue) m_rd++;
        end else if (dr) begin
            m_post = 1;
        end else begin
            m_busy = 1'b0;
        end
        m_lastrd   = issue;
        m_lastaddr = rd_before;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; compute_stall = 1'b0;
        model_reset();
        #1;
        check("rst_busy",     32'(busy),     32'(0));
        check("rst_address",  32'(address),  32'(0));
        check("rst_rd_valid", 32'(rd_valid), 32'(0));
        check("rst_bram_en",  32'(bram_en),  32'(0));
        @(negedge clk);
        #2 reset = 1'b1;

        // Back-to-back pass with fixed expected timing.
        for (int k = 0; k < 12; k++) begin
            cycle(k == 0, 1'b0, 1'b1, 1'b0);
            check("t_done",    32'(done),     32'(k == 10));
            check("t_rd_last", 32'(rd_last),  32'(k == 9));
            check("t_rd_vld",  32'(rd_valid), 32'(k >= 6 && k <= 9));
            check("t_busy",    32'(busy),     32'(k >= 1 && k <= 10));
        end

        // Loader toggles in_valid.
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 16; k++) cycle(1'b0, 1'b0, k[0] == 1'b0, 1'b0);

        // Two-cycle stall after the read of address 1.
        for (int k = 0; k < 14; k++) begin
            cycle(k == 0, 1'b0, 1'b1, (k == 7) || (k == 8));
            if (k == 7 || k == 8) begin
                check("stall_addr", 32'(address), 32'(2));
                check("stall_en",   32'(bram_en), 32'(0));
            end
            check("stall_done", 32'(done), 32'(k == 12));
        end

        // Abort in READ at address 2, then a full restart.
        for (int k = 0; k < 9; k++) cycle(k == 0, k == 7, 1'b1, 1'b0);
        check("abort_busy", 32'(busy), 32'(0));
        for (int k = 0; k < 12; k++) cycle(k == 0, 1'b0, 1'b1, 1'b0);

        // Async reset mid-LOAD.
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst_busy",     32'(busy),     32'(0));
        check("arst_in_ready", 32'(in_ready), 32'(0));
        check("arst_bram_en",  32'(bram_en),  32'(0));
        check("arst_address",  32'(address),  32'(0));
        model_reset();
        @(negedge clk);
        #2 reset = 1'b1;

        // Start held high through DONE.
        for (int k = 0; k < 16; k++) cycle(1'b1, 1'b0, 1'b1, 1'b0);

        // Random traffic.
        for (int k = 0; k < 500; k++)
            cycle(($urandom % 4) == 0, ($urandom % 32) == 0,
                  ($urandom % 2) == 0, ($urandom % 4) == 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
